id_ex_operand_stage: RTL and testbench

// - ID/EX pipeline register between the decoder/register file and the ALU stage.
// - Captures rs1/rs2 read data, applies EX/MEM and MEM/WB forwarding, and selects ALU operand B (reg or imm).
// - Detects load-use hazards against its held entry and inserts one bubble.
// - Uses a valid/ready handshake on both sides; a synchronous flush kills the held entry on branch redirect.

---
 rtl/id_ex_operand_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: captures register-file operands with EX/MEM and MEM/WB
// forwarding, selects ALU operand B, and inserts one bubble on a load-use hazard.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [DATA_W-1:0] imm,
    input  logic [OP_W-1:0]   alu_op,
    input  logic              use_imm,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic [ADDR_W-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [ADDR_W-1:0] out_rd,
    output logic [OP_W-1:0]   out_alu_op,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              load_use_stall
);

    logic              r_valid;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_rs2_data;
    logic [ADDR_W-1:0] r_rd;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_use_imm;
    logic [ADDR_W-1:0] r_rs1_addr;
    logic [ADDR_W-1:0] r_rs2_addr;

    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;
    logic              w_stall;
    logic              w_accept;
    logic              w_wb_hit1;
    logic              w_wb_hit2;

    // x0 is hard-wired zero; EX/MEM is the younger result and wins over MEM/WB.
    always_comb begin
        w_rs1_val = rf_data1;
        if (rs1_addr == '0)
            w_rs1_val = '0;
        else if (exmem_reg_write && exmem_rd == rs1_addr)
            w_rs1_val = exmem_data;
        else if (memwb_reg_write && memwb_rd == rs1_addr)
            w_rs1_val = memwb_data;
    end

    always_comb begin
        w_rs2_val = rf_data2;
        if (rs2_addr == '0)
            w_rs2_val = '0;
        else if (exmem_reg_write && exmem_rd == rs2_addr)
            w_rs2_val = exmem_data;
        else if (memwb_reg_write && memwb_rd == rs2_addr)
            w_rs2_val = memwb_data;
    end

    assign w_stall  = r_valid && r_mem_read && (r_rd != '0) && in_valid &&
                      ((r_rd == rs1_addr) || (r_rd == rs2_addr));
    assign in_ready = !w_stall && (!r_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    // A stalled entry can still pick up a result retiring through MEM/WB.
    assign w_wb_hit1 = memwb_reg_write && (r_rs1_addr != '0) && (memwb_rd == r_rs1_addr);
    assign w_wb_hit2 = memwb_reg_write && (r_rs2_addr != '0) && (memwb_rd == r_rs2_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rs2_data  <= '0;
            r_rd        <= '0;
            r_alu_op    <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_use_imm   <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_op_a      <= w_rs1_val;
            r_op_b      <= use_imm ? imm : w_rs2_val;
            r_rs2_data  <= w_rs2_val;
            r_rd        <= rd_addr;
            r_alu_op    <= alu_op;
            r_reg_write <= reg_write;
            r_mem_read  <= mem_read;
            r_use_imm   <= use_imm;
            r_rs1_addr  <= rs1_addr;
            r_rs2_addr  <= rs2_addr;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            if (w_wb_hit1)
                r_op_a <= memwb_data;
            if (w_wb_hit2) begin
                r_rs2_data <= memwb_data;
                if (!r_use_imm)
                    r_op_b <= memwb_data;
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_op_a       = r_op_a;
    assign out_op_b       = r_op_b;
    assign out_rs2_data   = r_rs2_data;
    assign out_rd         = r_rd;
    assign out_alu_op     = r_alu_op;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign load_use_stall = w_stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: table-driven forwarding vectors feeding
// a scoreboard queue, plus hand-written load-use, hold, flush and reset sequences.
module tb_id_ex_operand_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int OP_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [DATA_W-1:0] rf_data1, rf_data2, imm;
    logic [OP_W-1:0]   alu_op;
    logic              use_imm, reg_write, mem_read;
    logic [ADDR_W-1:0] exmem_rd, memwb_rd;
    logic              exmem_reg_write, memwb_reg_write;
    logic [DATA_W-1:0] exmem_data, memwb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_op_a, out_op_b, out_rs2_data;
    logic [ADDR_W-1:0] out_rd;
    logic [OP_W-1:0]   out_alu_op;
    logic              out_reg_write, out_mem_read, load_use_stall;

    id_ex_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .imm(imm), .alu_op(alu_op),
        .use_imm(use_imm), .reg_write(reg_write), .mem_read(mem_read),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_data(exmem_data),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] rs1, rs2, rd;
        logic [DATA_W-1:0] rf1, rf2, im;
        logic [OP_W-1:0]   op;
        logic              ui, rw, mr;
        logic [ADDR_W-1:0] exrd;
        logic              exw;
        logic [DATA_W-1:0] exd;
        logic [ADDR_W-1:0] wbrd;
        logic              wbw;
        logic [DATA_W-1:0] wbd;
        logic [DATA_W-1:0] ea, eb, e2;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] a, b, s2;
        logic [ADDR_W-1:0] rd;
        logic [OP_W-1:0]   op;
        logic              rw, mr;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rs1_addr = v.rs1; rs2_addr = v.rs2; rd_addr = v.rd;
        rf_data1 = v.rf1; rf_data2 = v.rf2; imm = v.im; alu_op = v.op;
        use_imm = v.ui; reg_write = v.rw; mem_read = v.mr;
        exmem_rd = v.exrd; exmem_reg_write = v.exw; exmem_data = v.exd;
        memwb_rd = v.wbrd; memwb_reg_write = v.wbw; memwb_data = v.wbd;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.a = v.ea; e.b = v.eb; e.s2 = v.e2; e.rd = v.rd; e.op = v.op; e.rw = v.rw; e.mr = v.mr;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty when output expected", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".op_a"}, out_op_a, e.a);
        chk({tag, ".op_b"}, out_op_b, e.b);
        chk({tag, ".rs2_data"}, out_rs2_data, e.s2);
        chk({tag, ".ctrl"}, {19'd0, out_rd, out_alu_op, out_reg_write, out_mem_read},
            {19'd0, e.rd, e.op, e.rw, e.mr});
    endtask

    function automatic vec_t mk(input logic [ADDR_W-1:0] rs1, rs2, rd,
                                input logic [DATA_W-1:0] rf1, rf2, im,
                                input logic [OP_W-1:0] op, input logic ui, rw, mr,
                                input logic [ADDR_W-1:0] exrd, input logic exw, input logic [DATA_W-1:0] exd,
                                input logic [ADDR_W-1:0] wbrd, input logic wbw, input logic [DATA_W-1:0] wbd,
                                input logic [DATA_W-1:0] ea, eb, e2);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rf1 = rf1; v.rf2 = rf2; v.im = im;
        v.op = op; v.ui = ui; v.rw = rw; v.mr = mr;
        v.exrd = exrd; v.exw = exw; v.exd = exd; v.wbrd = wbrd; v.wbw = wbw; v.wbd = wbd;
        v.ea = ea; v.eb = eb; v.e2 = e2;
        return v;
    endfunction

    initial begin
        // rs1 rs2 rd | rf1 rf2 imm | op ui rw mr | exmem rd/we/data | memwb rd/we/data | exp a, b, rs2
        vecs[0] = mk(5, 6, 1, 32'h10, 32'h20, 32'h0, 4'h1, 0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                     32'h10, 32'h20, 32'h20);
        vecs[1] = mk(3, 4, 2, 32'h11, 32'h44, 32'h0, 4'h2, 0, 1, 0, 3, 1, 32'hAA, 3, 1, 32'hBB,
                     32'hAA, 32'h44, 32'h44);
        vecs[2] = mk(0, 2, 3, 32'h99, 32'h22, 32'hFFFF_FFF0, 4'h3, 1, 0, 0, 0, 1, 32'h77, 0, 1, 32'h66,
                     32'h0, 32'hFFFF_FFF0, 32'h22);
        vecs[3] = mk(9, 10, 4, 32'h19, 32'h30, 32'h0, 4'h4, 0, 1, 0, 9, 0, 32'hCC, 9, 1, 32'hBB,
                     32'hBB, 32'h30, 32'h30);
        vecs[4] = mk(1, 12, 5, 32'h1, 32'h2, 32'h5, 4'h5, 1, 1, 0, 12, 1, 32'h1234, 0, 0, 32'h0,
                     32'h1, 32'h5, 32'h1234);
        vecs[5] = mk(7, 7, 6, 32'h70, 32'h71, 32'h0, 4'hF, 0, 0, 0, 8, 1, 32'h88, 7, 1, 32'hDEAD,
                     32'hDEAD, 32'hDEAD, 32'hDEAD);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        chk("reset.op_a", out_op_a, 32'd0);
        chk("reset.op_b", out_op_b, 32'd0);
        chk("reset.ctrl", {19'd0, out_rd, out_alu_op, out_reg_write, out_mem_read}, 32'd0);
        chk("reset.stall", {31'd0, load_use_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back accepts with out_ready=1: consume+accept every edge, no bubbles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
            if (in_valid && in_ready) push_exp(vecs[i]);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i));
        end

        // Load-use: lw x7 held, add x8,x7,x1 follows.
        @(negedge clk);
        apply(mk(1, 0, 7, 32'h100, 32'h0, 32'h0, 4'h0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 32'h0,
                 32'h100, 32'h0, 32'h0));
        @(posedge clk); #1;
        chk("lw.valid", {31'd0, out_valid}, 32'd1);
        chk("lw.mem_read", {31'd0, out_mem_read}, 32'd1);
        @(negedge clk);
        apply(mk(7, 1, 8, 32'h0BAD, 32'h3, 32'h0, 4'h6, 0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0,
                 32'h600D, 32'h3, 32'h3));
        #1;
        chk("hz.stall", {31'd0, load_use_stall}, 32'd1);
        chk("hz.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("hz.bubble", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        memwb_rd = 7; memwb_reg_write = 1'b1; memwb_data = 32'h600D;
        #1;
        chk("hz.stall_clear", {31'd0, load_use_stall}, 32'd0);
        chk("hz.in_ready2", {31'd0, in_ready}, 32'd1);
        if (in_valid && in_ready)
            push_exp(mk(7, 1, 8, 0, 0, 0, 4'h6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h600D, 32'h3, 32'h3));
        @(posedge clk); #1;
        check_out("hz.dep");

        // Hold: out_ready=0 for 3 cycles with new input pending.
        @(negedge clk);
        apply(mk(2, 3, 9, 32'h2, 32'h3, 32'h0, 4'h7, 0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("hold%0d.valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold%0d.op_a", c), out_op_a, 32'h600D);
            chk($sformatf("hold%0d.rd", c), {27'd0, out_rd}, 32'd8);
            @(negedge clk);
        end
        memwb_rd = 7; memwb_reg_write = 1'b1; memwb_data = 32'h55;
        @(posedge clk); #1;
        chk("hold.refresh_a", out_op_a, 32'h55);
        chk("hold.keep_b", out_op_b, 32'h3);
        chk("hold.rd", {27'd0, out_rd}, 32'd8);

        // Flush with in_valid and out_valid high.
        @(negedge clk);
        memwb_reg_write = 1'b0;
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush.no_capture", {31'd0, out_valid}, 32'd0);
        chk("flush.op_a_held", out_op_a, 32'h55);

        // Reset while full.
        @(negedge clk);
        apply(vecs[0]);
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        if (in_valid && in_ready) push_exp(vecs[0]);
        @(posedge clk); #1;
        check_out("prerst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid.valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid.op_a", out_op_a, 32'd0);
        chk("rst_mid.op_b", out_op_b, 32'd0);
        chk("rst_mid.ctrl", {19'd0, out_rd, out_alu_op, out_reg_write, out_mem_read}, 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid.no_replay", {31'd0, out_valid}, 32'd0);
        chk("sb.drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
